// File: rtl/sc_pio_pkg.sv
// Shared register map for the PIO output block with timed pulse inversion.
// Also holds the decoded write-kind enum used by the top-level decode.
package sc_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLR       = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
  localparam logic [2:0] ADDR_PULSE     = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;
  localparam logic [2:0] ADDR_RSVD      = 3'd7;

  typedef enum logic [2:0] {
    WR_NONE,
    WR_DATA,
    WR_SET,
    WR_CLR,
    WR_TOGGLE,
    WR_LEN,
    WR_PULSE
  } wr_kind_e;

  function automatic wr_kind_e decode_wr(input logic en, input logic [2:0] addr);
    wr_kind_e k;
    k = WR_NONE;
    if (en) begin
      case (addr)
        ADDR_DATA:      k = WR_DATA;
        ADDR_SET:       k = WR_SET;
        ADDR_CLR:       k = WR_CLR;
        ADDR_TOGGLE:    k = WR_TOGGLE;
        ADDR_PULSE_LEN: k = WR_LEN;
        ADDR_PULSE:     k = WR_PULSE;
        default:        k = WR_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/sc_pio_pulse_timer.sv
// Pulse mask and down-counter: arms/retriggers on PULSE writes, clears the
// whole mask together when the shared count expires.
module sc_pio_pulse_timer #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm_i,
  input  logic [WIDTH-1:0] bits_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [WIDTH-1:0] mask_o,
  output logic             busy_o
);

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arm_ok, expire;

  assign arm_ok = arm_i && (len_i != '0) && (bits_i != '0);
  assign expire = (cnt_q == CNT_W'(1));

  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (arm_ok) begin
      // A retrigger on the expiry edge starts fresh: the old bits have already
      // served their full length, so only the new bits stay inverted.
      mask_d = expire ? bits_i : (mask_q | bits_i);
      cnt_d  = len_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (expire) mask_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mask_o = mask_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/sc_pio_output_pulse.sv
// Avalon-MM PIO output port with set/clear/toggle and timed pulse inversion.
// out_port = data register XOR active pulse mask; reads are zero-wait.
module sc_pio_output_pulse
  import sc_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 21,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  wr_kind_e         wr_kind;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] mask;
  logic             busy;
  logic             unused_wd;

  assign wr_kind   = decode_wr(chipselect & ~write_n, address);
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    case (wr_kind)
      WR_DATA:   data_d = wd;
      WR_SET:    data_d = data_q | wd;
      WR_CLR:    data_d = data_q & ~wd;
      WR_TOGGLE: data_d = data_q ^ wd;
      WR_LEN:    len_d  = writedata[CNT_W-1:0];
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      len_q  <= '0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
    end
  end

  // The timer sees the pre-write PULSE_LEN, so a length write in the same
  // cycle as an arm only affects later arms.
  sc_pio_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .arm_i  (wr_kind == WR_PULSE),
    .bits_i (wd),
    .len_i  (len_q),
    .mask_o (mask),
    .busy_o (busy)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET,
      ADDR_CLR, ADDR_TOGGLE: readdata[WIDTH-1:0] = data_q;
      ADDR_PULSE_LEN:        readdata[CNT_W-1:0] = len_q;
      ADDR_PULSE:            readdata[WIDTH-1:0] = mask;
      ADDR_STATUS:           readdata[0]         = busy;
      default:               readdata            = '0;
    endcase
  end

  assign out_port   = data_q ^ mask;
  assign pulse_busy = busy;

endmodule

// File: doc/sc_pio_output_pulse.md
SC_PIO_OUTPUT_PULSE -- requirements
Module: sc_pio_output_pulse

Interface
REQ-001 SHALL have parameter WIDTH, default 21, output port width (legal 1..32).
REQ-002 SHALL have parameter CNT_W, default 16, pulse-length counter width (legal 1..32).
REQ-003 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit reset value of the data register.
REQ-004 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  read data, zero wait states, combinational from registers.
REQ-011 SHALL have port out_port  output  WIDTH  driven pins.
REQ-012 SHALL have port pulse_busy  output  1  high while any pulse is active.

Function
REQ-013 SHALL accept a write when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used, except PULSE_LEN, which uses [CNT_W-1:0].
REQ-014 SHALL decode the register map: 0 DATA (R/W, replace), 1 SET (W, data |= wd), 2 CLR (W, data &= ~wd), 3 TOGGLE (W, data ^= wd), 4 PULSE_LEN (R/W), 5 PULSE (W, arm pulse; read returns active mask), 6 STATUS (R, bit0 = pulse_busy), 7 reserved.
REQ-015 SHALL return DATA on reads of addresses 0-3, zero-extended to 32 bits; addresses 7 and unused upper bits SHALL read as 0.
REQ-016 SHALL drive out_port = data_reg XOR pulse_mask, both registered; a write accepted at edge k SHALL be visible on out_port immediately after edge k.
REQ-017 SHALL, on a PULSE write with PULSE_LEN != 0 and wd[WIDTH-1:0] != 0, set pulse_mask |= wd and load the counter with PULSE_LEN.
REQ-018 SHALL decrement the counter once per cycle while it is nonzero; on the edge where it goes 1->0 it SHALL clear pulse_mask, so each armed bit is inverted for exactly PULSE_LEN cycles.
REQ-019 SHALL ignore PULSE writes when PULSE_LEN=0 or wd[WIDTH-1:0]=0; neither the mask nor the counter changes.
REQ-020 SHALL retrigger on a PULSE write while busy: OR the new bits into the mask and reload the counter; every masked bit then ends together.
REQ-021 SHALL let a PULSE write win over counter expiry in the same cycle, so the mask becomes the new wd only and the counter is reloaded.
REQ-022 SHALL let DATA/SET/CLR/TOGGLE writes during a pulse update data_reg without affecting the mask or the counter.
REQ-023 SHALL apply a PULSE_LEN write during a pulse only to the next arm; the running count is unaffected.
REQ-024 SHALL drive pulse_busy = (counter != 0).

Reset
REQ-025 SHALL on reset set data_reg=RESET_VALUE, pulse_mask=0, counter=0 and PULSE_LEN=0, so that out_port=RESET_VALUE and pulse_busy=0.
REQ-026 SHALL abort an active pulse on reset with no further inversion, and SHALL give reset priority over a simultaneous write.

Structure
REQ-027 SHALL place the register address constants (ADDR_DATA..ADDR_STATUS) in shared package sc_pio_pkg.
REQ-028 SHALL implement the counter, mask and retrigger logic in sub-module sc_pio_pulse_timer (params WIDTH, CNT_W); register decode and readdata muxing SHALL stay in the top level.

Verification
REQ-029 SHALL cover: WIDTH=21, write DATA=0x1FFFFF, CLR 0x0000F0, TOGGLE 0x000001 -> out_port=0x1FFF0E, DATA reads 0x001FFF0E.
REQ-030 SHALL cover: PULSE_LEN=5, DATA=0, PULSE 0x3 -> out_port=0x3 for exactly 5 cycles then 0; pulse_busy is high for the same 5 cycles.
REQ-031 SHALL cover: PULSE_LEN=4, PULSE 0x1, PULSE 0x4 two cycles later -> bits 0 and 2 both inverted until 4 cycles after the second write.
REQ-032 SHALL cover: PULSE_LEN=0 then PULSE 0xFF -> no change on out_port and pulse_busy stays 0.
REQ-033 SHALL cover: reset asserted mid-pulse with RESET_VALUE=0x5 -> next cycle out_port=0x5, STATUS reads 0, PULSE_LEN reads 0.
REQ-034 SHALL cover: PULSE 0x2 written on the expiry cycle of a 0x1 pulse -> mask=0x2 and counter reloaded.
